// File: rtl/alu.sv
// 8-bit registered ALU: eight unsigned operations on zero-extended operands,
// result captured into a 16-bit register when enabled.
module alu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [2:0]  sel,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] z
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned RES_W = 16;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'd0;
  localparam logic [SEL_W-1:0] OP_SUB = 3'd1;
  localparam logic [SEL_W-1:0] OP_MUL = 3'd2;
  localparam logic [SEL_W-1:0] OP_SHL = 3'd3;
  localparam logic [SEL_W-1:0] OP_SHR = 3'd4;
  localparam logic [SEL_W-1:0] OP_AND = 3'd5;
  localparam logic [SEL_W-1:0] OP_OR  = 3'd6;
  localparam logic [SEL_W-1:0] OP_XOR = 3'd7;

  logic [RES_W-1:0] x_ext;
  logic [RES_W-1:0] y_ext;
  logic             shamt_big;
  logic [3:0]       shamt;
  logic [RES_W-1:0] result_c;
  logic [RES_W-1:0] z_d;
  logic [RES_W-1:0] z_q;

  assign x_ext     = RES_W'(x);
  assign y_ext     = RES_W'(y);
  // Shift distances of 16 or more clear the whole 16-bit value.
  assign shamt_big = (y >= OP_W'(16));
  assign shamt     = y[3:0];

  // Operation decode; every select value is defined.
  always_comb begin
    result_c = '0;
    case (sel)
      OP_ADD: result_c = x_ext + y_ext;
      OP_SUB: result_c = x_ext - y_ext;
      OP_MUL: result_c = x_ext * y_ext;
      OP_SHL: result_c = shamt_big ? '0 : (x_ext << shamt);
      OP_SHR: result_c = shamt_big ? '0 : (x_ext >> shamt);
      OP_AND: result_c = x_ext & y_ext;
      OP_OR:  result_c = x_ext | y_ext;
      OP_XOR: result_c = x_ext ^ y_ext;
      default: result_c = '0;
    endcase
  end

  always_comb begin
    z_d = z_q;
    if (en) z_d = result_c;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) z_q <= '0;
    else       z_q <= z_d;
  end

  assign z = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu with hand-computed expected results.
module tb_alu;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [2:0]  sel;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [15:0] z;

  int n_checks;
  int n_pass;

  alu dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .sel  (sel),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one enabled operation and compare z just after the loading edge.
  task automatic do_op(input string tag, input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    en  = 1'b1;
    sel = s;
    x   = a;
    y   = b;
    @(posedge clk);
    #1 check(tag, z, exp);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    en   = 1'b0;
    sel  = 3'd0;
    x    = 8'd0;
    y    = 8'd0;

    @(posedge clk);
    #1 check("reset_z", z, 16'h0000);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", z, 16'h0000);

    @(negedge clk);
    x  = 8'd5;
    y  = 8'd5;
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_en_ignored", z, 16'h0000);

    @(negedge clk);
    rstn = 1'b1;
    en   = 1'b0;

    do_op("add_5_5",   3'd0, 8'd5,  8'd5, 16'd10);
    do_op("sub_10_3",  3'd1, 8'd10, 8'd3, 16'd7);
    do_op("mul_5_5",   3'd2, 8'd5,  8'd5, 16'd25);
    do_op("shl_64_2",  3'd3, 8'd64, 8'd2, 16'd256);
    do_op("shr_64_2",  3'd4, 8'd64, 8'd2, 16'd16);
    do_op("and_2_3",   3'd5, 8'd2,  8'd3, 16'd2);
    do_op("or_2_3",    3'd6, 8'd2,  8'd3, 16'd3);
    do_op("xor_2_3",   3'd7, 8'd2,  8'd3, 16'd1);

    do_op("sub_wrap",  3'd1, 8'd3,   8'd10,  16'hFFF9);
    do_op("mul_max",   3'd2, 8'd255, 8'd255, 16'd65025);
    do_op("add_max",   3'd0, 8'd255, 8'd255, 16'd510);
    do_op("shl_255_8", 3'd3, 8'd255, 8'd8,   16'hFF00);
    do_op("shl_1_15",  3'd3, 8'd1,   8'd15,  16'h8000);
    do_op("shl_1_16",  3'd3, 8'd1,   8'd16,  16'h0000);
    do_op("shl_1_255", 3'd3, 8'd1,   8'd255, 16'h0000);
    do_op("shr_128_7", 3'd4, 8'd128, 8'd7,   16'd1);
    do_op("shr_128_9", 3'd4, 8'd128, 8'd9,   16'h0000);
    do_op("and_hi",    3'd5, 8'hF0,  8'hFF,  16'h00F0);
    do_op("xor_ff",    3'd7, 8'hFF,  8'h0F,  16'h00F0);

    do_op("hold_load", 3'd0, 8'd5, 8'd5, 16'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en  = 1'b0;
      sel = 3'(i + 1);
      x   = 8'(200 + i);
      y   = 8'(7 * i + 1);
      @(posedge clk);
      #1 check($sformatf("hold_%0d", i), z, 16'd10);
    end

    do_op("pre_reset", 3'd2, 8'd5, 8'd5, 16'd25);
    @(negedge clk);
    en  = 1'b1;
    sel = 3'd0;
    x   = 8'd1;
    y   = 8'd2;
    #1 rstn = 1'b0;
    #1 check("async_clear", z, 16'h0000);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1 check("post_release_load", z, 16'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
